// File: rtl/dffram_pkg.sv
// Shared types and helpers for the two-port DFF RAM.
package dffram_pkg;

   // Width of one byte lane.
   localparam int LANE_W    = 8;
   // Widest word the lane-merge helper handles (in lanes).
   localparam int MAX_LANES = 16;

   typedef enum logic [0:0] {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_t;

   typedef logic [LANE_W*MAX_LANES-1:0] lane_word_t;

   // Take each lane from new_w where its enable is set, else keep old_w.
   function automatic lane_word_t merge_lanes(input lane_word_t            old_w,
                                              input lane_word_t            new_w,
                                              input logic [MAX_LANES-1:0]  lane_en);
      lane_word_t m;
      m = old_w;
      for (int i = 0; i < MAX_LANES; i++) begin
         if (lane_en[i]) begin
            m[i*LANE_W +: LANE_W] = new_w[i*LANE_W +: LANE_W];
         end else begin
            m[i*LANE_W +: LANE_W] = old_w[i*LANE_W +: LANE_W];
         end
      end
      return m;
   endfunction

endpackage

// File: rtl/dffram_2p_if.sv
// Bus bundle for dffram_2p: clear request, ready, read/write port 0, read port 1.
interface dffram_2p_if #(
   parameter int WSIZE = 4,
   parameter int AW    = 9
);
   import dffram_pkg::*;

   localparam int DW = LANE_W * WSIZE;

   logic             CLR;
   logic             READY;
   logic             EN0;
   logic [WSIZE-1:0] WE0;
   logic [AW-1:0]    A0;
   logic [DW-1:0]    Di0;
   logic [DW-1:0]    Do0;
   logic             EN1;
   logic [AW-1:0]    A1;
   logic [DW-1:0]    Do1;

   modport master (
      output CLR, EN0, WE0, A0, Di0, EN1, A1,
      input  READY, Do0, Do1
   );

   modport slave (
      input  CLR, EN0, WE0, A0, Di0, EN1, A1,
      output READY, Do0, Do1
   );

endinterface

// File: rtl/dffram_clear_seq.sv
// Clear sequencer: walks every address writing zero after reset or on request,
// then reports the array as ready.
module dffram_clear_seq
   import dffram_pkg::*;
#(
   parameter int AW = 9
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          clr,
   output logic          ready,
   output logic          clr_we,
   output logic [AW-1:0] clr_addr
);

   state_t        state_r;
   state_t        state_next_s;
   logic [AW-1:0] cnt_r;
   logic [AW-1:0] cnt_next_s;
   logic          ready_r;

   // State, counter and ready flag; reset restarts the clear from address 0.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_r <= CLEAR;
         cnt_r   <= {AW{1'b0}};
         ready_r <= 1'b0;
      end else begin
         state_r <= state_next_s;
         cnt_r   <= cnt_next_s;
         ready_r <= (state_next_s == RUN);
      end
   end

   // Next state: count through the array in CLEAR; CLR only restarts from RUN.
   always_comb begin
      state_next_s = state_r;
      cnt_next_s   = cnt_r;
      clr_we       = 1'b0;
      case (state_r)
         CLEAR: begin
            clr_we     = 1'b1;
            cnt_next_s = cnt_r + {{(AW-1){1'b0}}, 1'b1};
            if (cnt_r == {AW{1'b1}}) begin
               state_next_s = RUN;
            end else begin
               state_next_s = CLEAR;
            end
         end
         RUN: begin
            if (clr) begin
               state_next_s = CLEAR;
               cnt_next_s   = {AW{1'b0}};
            end else begin
               state_next_s = RUN;
            end
         end
         default: begin
            state_next_s = CLEAR;
            cnt_next_s   = {AW{1'b0}};
         end
      endcase
   end

   assign ready    = ready_r;
   assign clr_addr = cnt_r;

endmodule

// File: rtl/dffram_2p.sv
// Two-port DFF RAM: port 0 read/write with byte enables, port 1 read-only,
// optional write-to-read bypass and optional second output stage.
module dffram_2p
   import dffram_pkg::*;
#(
   parameter int WSIZE   = 4,
   parameter int AW      = 9,
   parameter int OUT_REG = 0,
   parameter int BYPASS  = 1
) (
   input logic        CLK,
   input logic        RST,
   dffram_2p_if.slave bus
);

   localparam int DW    = LANE_W * WSIZE;
   localparam int DEPTH = 2 ** AW;

   logic          ready_s;
   logic          clr_we_s;
   logic [AW-1:0] clr_addr_s;

   logic [DW-1:0] mem_r [DEPTH];

   logic [DW-1:0] old0_s;
   logic [DW-1:0] old1_s;
   logic [DW-1:0] merged_s;
   logic [DW-1:0] rd1_data_s;
   logic          rd0_s;
   logic          wr0_s;
   logic          rd1_s;
   logic          collide_s;

   logic [DW-1:0] do0_s1_r;
   logic [DW-1:0] do1_s1_r;

   dffram_clear_seq #(.AW(AW)) u_clear_seq (
      .CLK      (CLK),
      .RST      (RST),
      .clr      (bus.CLR),
      .ready    (ready_s),
      .clr_we   (clr_we_s),
      .clr_addr (clr_addr_s)
   );

   assign bus.READY = ready_s;

   // Port decode: user accesses only count while ready; merge lanes for write-first.
   always_comb begin
      old0_s     = mem_r[bus.A0];
      old1_s     = mem_r[bus.A1];
      merged_s   = DW'(merge_lanes(lane_word_t'(old0_s), lane_word_t'(bus.Di0),
                                   MAX_LANES'(bus.WE0)));
      rd0_s      = ready_s & bus.EN0;
      wr0_s      = rd0_s & (|bus.WE0);
      rd1_s      = ready_s & bus.EN1;
      collide_s  = wr0_s & (bus.A0 == bus.A1);
      rd1_data_s = old1_s;
      if ((BYPASS != 0) && collide_s) begin
         rd1_data_s = merged_s;
      end else begin
         rd1_data_s = old1_s;
      end
   end

   // Array write port: the clear sequencer owns it while clearing, port 0 otherwise.
   always_ff @(posedge CLK) begin
      if (clr_we_s) begin
         mem_r[clr_addr_s] <= {DW{1'b0}};
      end else if (wr0_s) begin
         mem_r[bus.A0] <= merged_s;
      end
   end

   // First output stage: load on an enabled access, otherwise hold.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         do0_s1_r <= {DW{1'b0}};
         do1_s1_r <= {DW{1'b0}};
      end else begin
         if (rd0_s) begin
            do0_s1_r <= merged_s;
         end
         if (rd1_s) begin
            do1_s1_r <= rd1_data_s;
         end
      end
   end

   if (OUT_REG != 0) begin : g_out_reg
      logic          ld0_r;
      logic          ld1_r;
      logic [DW-1:0] do0_s2_r;
      logic [DW-1:0] do1_s2_r;

      // Second stage follows the first one cycle later, so holds propagate too.
      always_ff @(posedge CLK or posedge RST) begin
         if (RST) begin
            ld0_r    <= 1'b0;
            ld1_r    <= 1'b0;
            do0_s2_r <= {DW{1'b0}};
            do1_s2_r <= {DW{1'b0}};
         end else begin
            ld0_r <= rd0_s;
            ld1_r <= rd1_s;
            if (ld0_r) begin
               do0_s2_r <= do0_s1_r;
            end
            if (ld1_r) begin
               do1_s2_r <= do1_s1_r;
            end
         end
      end

      assign bus.Do0 = do0_s2_r;
      assign bus.Do1 = do1_s2_r;
   end else begin : g_no_out_reg
      assign bus.Do0 = do0_s1_r;
      assign bus.Do1 = do1_s1_r;
   end

endmodule
